// File: rtl/rule_seq_detector.sv
// Cycle-accurate detector for trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans.
// Define SEQ_DET_FAIL_EN to compile in failure accounting (fail / fail_cnt); otherwise both read 0.
module rule_seq_detector #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             trans,
    input  logic             start_trans,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             end_trans,
    output logic             match,
    output logic             active,
    output logic [CNT_W-1:0] attempt_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [TS_W-1:0]  last_match_ts,
    output logic             fail,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [4:0]      st;
    logic [TS_W-1:0] cyc_cnt;
    logic            start;
    logic            hit;

    assign start  = trans & en;
    assign hit    = st[4] & end_trans;
    assign active = |st;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Each st bit is an independent thread, so overlapping attempts need no extra state.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            st    <= '0;
            match <= 1'b0;
        end else begin
            st    <= {st[3] & c, st[2] & b, st[1] & a, st[0] & start_trans, start};
            match <= hit;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + TS_W'(1);
        end
    end

    // clr takes priority over any increment landing on the same edge.
    always_ff @(posedge sysclk) begin
        if (rst || clr) begin
            attempt_cnt   <= '0;
            match_cnt     <= '0;
            last_match_ts <= '0;
        end else begin
            if (start) begin
                attempt_cnt <= sat_inc(attempt_cnt);
            end
            if (hit) begin
                match_cnt     <= sat_inc(match_cnt);
                last_match_ts <= cyc_cnt;
            end
        end
    end

`ifdef SEQ_DET_FAIL_EN
    logic [4:0]       fail_vec;
    logic [2:0]       fail_num;
    logic [CNT_W+2:0] fail_sum;

    assign fail_vec = st & ~{end_trans, c, b, a, start_trans};

    always_comb begin
        fail_num = '0;
        for (int i = 0; i < 5; i++) begin
            fail_num = fail_num + {2'b00, fail_vec[i]};
        end
    end

    // Up to five threads can die together, so saturate on the widened sum.
    assign fail_sum = {3'b000, fail_cnt} + {{CNT_W{1'b0}}, fail_num};

    always_ff @(posedge sysclk) begin
        if (rst) begin
            fail     <= 1'b0;
            fail_cnt <= '0;
        end else begin
            fail <= |fail_vec;
            if (clr) begin
                fail_cnt <= '0;
            end else if (fail_sum > {3'b000, CNT_MAX}) begin
                fail_cnt <= CNT_MAX;
            end else begin
                fail_cnt <= fail_sum[CNT_W-1:0];
            end
        end
    end
`else
    assign fail     = 1'b0;
    assign fail_cnt = '0;
`endif

endmodule
